// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V front end.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef logic [XLEN-1:0] instr_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: each entry holds {instr, pc}. The PC of every issued request is
// queued in a tag queue at fire time and paired with its data when the response is kept.
module fetch_fifo #(
    parameter int WIDTH = riscv_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      tag_wr,
    input  logic [WIDTH-1:0]          tag_pc,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head_data,
    output logic [WIDTH-1:0]          head_pc,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [2*WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0]   tag_r [DEPTH];
    logic [AW-1:0]      wp_r;
    logic [AW-1:0]      rp_r;
    logic [AW-1:0]      tag_wp_r;
    logic [AW-1:0]      tag_rp_r;
    logic [AW:0]        count_r;
    logic               push_ok_s;
    logic               pop_ok_s;
    logic [2*WIDTH-1:0] head_s;

    assign empty     = (count_r == {(AW+1){1'b0}});
    assign full      = (count_r == FULL_COUNT);
    assign count     = count_r;
    assign head_data = head_s[2*WIDTH-1:WIDTH];
    assign head_pc   = head_s[WIDTH-1:0];

    // Qualify push/pop: flush wins, pops on an empty buffer are ignored (no bypass).
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (pop && !empty && !flush) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push && !flush && (!full || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Head entry, forced to zero while the buffer is empty.
    always_comb begin
        head_s = {(2*WIDTH){1'b0}};
        if (!empty) begin
            head_s = mem_r[rp_r];
        end else begin
            head_s = {(2*WIDTH){1'b0}};
        end
    end

    // Pointers and occupancy for both the data buffer and the tag queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_r     <= {AW{1'b0}};
            rp_r     <= {AW{1'b0}};
            tag_wp_r <= {AW{1'b0}};
            tag_rp_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (flush) begin
            wp_r     <= {AW{1'b0}};
            rp_r     <= {AW{1'b0}};
            tag_wp_r <= {AW{1'b0}};
            tag_rp_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wp_r     <= wp_r + AW'(1);
                tag_rp_r <= tag_rp_r + AW'(1);
            end
            if (pop_ok_s) begin
                rp_r <= rp_r + AW'(1);
            end
            if (tag_wr) begin
                tag_wp_r <= tag_wp_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage: tags captured at request fire, {data, tag} captured at kept response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(2*WIDTH){1'b0}};
                tag_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wp_r] <= {push_data, tag_r[tag_rp_r]};
            end
            if (tag_wr && !flush) begin
                tag_r[tag_wp_r] <= tag_pc;
            end
        end
    end

    fetch_fifo_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .push   (push),
        .pop_ok (pop_ok_s),
        .full   (full)
    );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Protocol checker for fetch_fifo: the fetch credit must keep pushes from hitting a full buffer.
module fetch_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic flush,
    input logic push,
    input logic pop_ok,
    input logic full
);

    // A push into a full buffer that is not being drained in the same cycle is lost data.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && full && !pop_ok))
        else $error("fetch_fifo overflow");

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, credit-limited in-order requests, response
// discard after redirect, and the instruction buffer feeding decode.
module instr_fetch_unit #(
    parameter int                        XLEN     = riscv_pkg::XLEN,
    parameter logic [riscv_pkg::XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
    parameter int                        DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW+1:0] CREDIT_LIMIT = (CW+2)'(DEPTH);

    logic [XLEN-1:0] pc_r;
    logic [CW:0]     in_flight_r;
    logic [CW:0]     discard_r;
    logic [CW:0]     fifo_count_s;
    logic [CW+1:0]   occupancy_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic            req_valid_s;
    logic            fire_s;
    logic            keep_s;
    logic            pop_s;
    logic [XLEN-1:0] pc_next_s;
    logic [CW:0]     in_flight_next_s;
    logic [CW:0]     discard_next_s;

    assign imem_req_valid = req_valid_s;
    assign imem_addr      = pc_r;
    assign instr_valid    = !fifo_empty_s;

    // Credit check: outstanding requests plus buffered words never exceed DEPTH.
    always_comb begin
        occupancy_s = {1'b0, in_flight_r} + {1'b0, fifo_count_s};
        req_valid_s = 1'b0;
        if (rst_n && !redirect_valid && !fifo_full_s && (occupancy_s < CREDIT_LIMIT)) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        fire_s = req_valid_s && imem_req_ready;
        pop_s  = !fifo_empty_s && instr_ready;
    end

    // A response is kept only when no stale responses remain and no redirect is flushing.
    always_comb begin
        keep_s = 1'b0;
        if (imem_rsp_valid && !redirect_valid && (discard_r == {(CW+1){1'b0}})) begin
            keep_s = 1'b1;
        end else begin
            keep_s = 1'b0;
        end
    end

    // Next PC, outstanding count and discard count; redirect overrides everything else.
    always_comb begin
        pc_next_s        = pc_r;
        in_flight_next_s = in_flight_r;
        discard_next_s   = discard_r;

        if (redirect_valid) begin
            pc_next_s = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (fire_s) begin
            pc_next_s = pc_r + XLEN'(4);
        end else begin
            pc_next_s = pc_r;
        end

        case ({fire_s, imem_rsp_valid})
            2'b10:   in_flight_next_s = in_flight_r + (CW+1)'(1);
            2'b01:   in_flight_next_s = in_flight_r - (CW+1)'(1);
            default: in_flight_next_s = in_flight_r;
        endcase

        if (redirect_valid) begin
            // Every response still owed after this cycle belongs to the old path.
            discard_next_s = in_flight_r - {{CW{1'b0}}, imem_rsp_valid};
        end else if (imem_rsp_valid && (discard_r != {(CW+1){1'b0}})) begin
            discard_next_s = discard_r - (CW+1)'(1);
        end else begin
            discard_next_s = discard_r;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= RESET_PC;
            in_flight_r <= {(CW+1){1'b0}};
            discard_r   <= {(CW+1){1'b0}};
        end else begin
            pc_r        <= pc_next_s;
            in_flight_r <= in_flight_next_s;
            discard_r   <= discard_next_s;
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .tag_wr    (fire_s),
        .tag_pc    (pc_r),
        .push      (keep_s),
        .push_data (imem_rsp_data),
        .pop       (pop_s),
        .head_data (instr),
        .head_pc   (instr_pc),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

endmodule
